wb_arbiter: RTL and testbench

- Writeback stage directly upstream of the register file; owns its single write port (rd_we / rd_idx / rd_data).
- Merges two result sources onto that port:
  - the in-order execute pipeline (single cycle, no backpressure except an explicit stall);
  - the long-latency unit (loads, mul/div) through a valid/ready handshake.
- Keeps a 32-bit pending-destination scoreboard so decode can interlock on registers still awaiting a long-latency result.
- Bounds starvation of the long-latency unit with a wait counter.

---
 rtl/wb_arbiter.sv | 108 ++++++++++
 tb/tb_wb_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges in-order EX results and long-latency results onto the single regfile write port.
// Latency: 1 cycle (result accepted in N drives o_rd_* in N+1); LSU throttled by o_lsu_ready, EX by o_ex_stall.
module wb_arbiter #(
    parameter int WAIT_MAX = 4,
    parameter int CNT_W    = 4
) (
    input  logic        clk_sys,
    input  logic        rst_sys,

    input  logic        i_pip_flush,

    input  logic        i_ex_valid,
    input  logic        i_ex_rd_we,
    input  logic [4:0]  i_ex_rd_idx,
    input  logic [31:0] i_ex_rd_data,
    output logic        o_ex_stall,

    input  logic        i_lsu_valid,
    output logic        o_lsu_ready,
    input  logic [4:0]  i_lsu_rd_idx,
    input  logic [31:0] i_lsu_rd_data,

    input  logic        i_lsu_issue,
    input  logic [4:0]  i_lsu_issue_idx,
    output logic [31:0] o_busy_mask,

    output logic        o_rd_we,
    output logic [4:0]  o_rd_idx,
    output logic [31:0] o_rd_data
);

    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

    logic             ex_req;
    logic             grant_lsu;
    logic             issue_set;

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]      busy_q,     busy_d;
    logic             rd_we_q,    rd_we_d;
    logic [4:0]       rd_idx_q,   rd_idx_d;
    logic [31:0]      rd_data_q,  rd_data_d;

    // Writes to x0 or without a destination never compete for the port.
    assign ex_req    = i_ex_valid & i_ex_rd_we & (i_ex_rd_idx != 5'd0) & ~i_pip_flush;
    assign grant_lsu = i_lsu_valid & (~ex_req | (wait_cnt_q >= WAIT_LIM));
    assign issue_set = i_lsu_issue & ~i_pip_flush & (i_lsu_issue_idx != 5'd0);

    assign o_lsu_ready = grant_lsu;
    assign o_ex_stall  = ex_req & grant_lsu;

    always_comb begin
        rd_we_d   = 1'b0;
        rd_idx_d  = rd_idx_q;
        rd_data_d = rd_data_q;
        if (grant_lsu) begin
            rd_we_d   = (i_lsu_rd_idx != 5'd0);
            rd_idx_d  = i_lsu_rd_idx;
            rd_data_d = i_lsu_rd_data;
        end else if (ex_req) begin
            rd_we_d   = 1'b1;
            rd_idx_d  = i_ex_rd_idx;
            rd_data_d = i_ex_rd_data;
        end
    end

    // Counts only while the LSU is actually being held off; any gap or accept restarts it.
    always_comb begin
        wait_cnt_d = '0;
        if (i_lsu_valid && !grant_lsu) begin
            wait_cnt_d = (wait_cnt_q >= WAIT_LIM) ? WAIT_LIM : wait_cnt_q + 1'b1;
        end
    end

    // Set is applied after clear so a same-index issue/retire leaves the bit pending.
    always_comb begin
        busy_d = busy_q;
        if (grant_lsu) begin
            busy_d[i_lsu_rd_idx] = 1'b0;
        end
        if (issue_set) begin
            busy_d[i_lsu_issue_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            wait_cnt_q <= '0;
            busy_q     <= '0;
            rd_we_q    <= 1'b0;
            rd_idx_q   <= 5'd0;
            rd_data_q  <= 32'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            busy_q     <= busy_d;
            rd_we_q    <= rd_we_d;
            rd_idx_q   <= rd_idx_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign o_busy_mask = busy_q;
    assign o_rd_we     = rd_we_q;
    assign o_rd_idx    = rd_idx_q;
    assign o_rd_data   = rd_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus a randomized run against a rule-level reference model.
module tb_wb_arbiter;

    localparam int WAIT_MAX = 4;

    logic        clk_sys = 1'b0;
    logic        rst_sys;
    logic        i_pip_flush;
    logic        i_ex_valid, i_ex_rd_we;
    logic [4:0]  i_ex_rd_idx;
    logic [31:0] i_ex_rd_data;
    logic        o_ex_stall;
    logic        i_lsu_valid, o_lsu_ready;
    logic [4:0]  i_lsu_rd_idx;
    logic [31:0] i_lsu_rd_data;
    logic        i_lsu_issue;
    logic [4:0]  i_lsu_issue_idx;
    logic [31:0] o_busy_mask;
    logic        o_rd_we;
    logic [4:0]  o_rd_idx;
    logic [31:0] o_rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    wb_arbiter #(.WAIT_MAX(WAIT_MAX), .CNT_W(4)) dut (
        .clk_sys(clk_sys), .rst_sys(rst_sys), .i_pip_flush(i_pip_flush),
        .i_ex_valid(i_ex_valid), .i_ex_rd_we(i_ex_rd_we), .i_ex_rd_idx(i_ex_rd_idx),
        .i_ex_rd_data(i_ex_rd_data), .o_ex_stall(o_ex_stall),
        .i_lsu_valid(i_lsu_valid), .o_lsu_ready(o_lsu_ready), .i_lsu_rd_idx(i_lsu_rd_idx),
        .i_lsu_rd_data(i_lsu_rd_data), .i_lsu_issue(i_lsu_issue), .i_lsu_issue_idx(i_lsu_issue_idx),
        .o_busy_mask(o_busy_mask), .o_rd_we(o_rd_we), .o_rd_idx(o_rd_idx), .o_rd_data(o_rd_data)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle();
        i_pip_flush = 0; i_ex_valid = 0; i_ex_rd_we = 0; i_ex_rd_idx = 0; i_ex_rd_data = 0;
        i_lsu_valid = 0; i_lsu_rd_idx = 0; i_lsu_rd_data = 0; i_lsu_issue = 0; i_lsu_issue_idx = 0;
    endtask

    task automatic ex_drive(input logic [4:0] idx, input logic [31:0] data);
        i_ex_valid = 1; i_ex_rd_we = 1; i_ex_rd_idx = idx; i_ex_rd_data = data;
    endtask

    task automatic test_reset();
        idle();
        ex_drive(5'd5, 32'h1);
        i_lsu_issue = 1; i_lsu_issue_idx = 5'd9;
        tick();
        idle();
        #2 rst_sys = 1;
        #1;
        n_tests++; if (o_rd_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b want 0", o_rd_we); end
        n_tests++; if (o_busy_mask !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", o_busy_mask); end
        n_tests++; if (o_rd_idx !== 5'd0 || o_rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_idx_data: got %0d/%h want 0/0", o_rd_idx, o_rd_data); end
        tick();
        rst_sys = 0;
        tick(); tick();
        n_tests++; if (o_rd_we !== 1'b0) begin n_fail++; $display("FAIL reset_idle_we: got %0b want 0", o_rd_we); end
    endtask

    task automatic test_ex_only();
        idle();
        ex_drive(5'd5, 32'hDEADBEEF);
        #1;
        n_tests++; if (o_ex_stall !== 1'b0) begin n_fail++; $display("FAIL ex_stall: got %0b want 0", o_ex_stall); end
        tick();
        idle();
        n_tests++; if (o_rd_we !== 1'b1 || o_rd_idx !== 5'd5 || o_rd_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL ex_write: got we=%0b idx=%0d data=%h want 1/5/deadbeef", o_rd_we, o_rd_idx, o_rd_data); end
        tick();
        n_tests++; if (o_rd_we !== 1'b0 || o_rd_idx !== 5'd5 || o_rd_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL ex_hold: got we=%0b idx=%0d data=%h want 0/5/deadbeef", o_rd_we, o_rd_idx, o_rd_data); end
    endtask

    task automatic test_x0_flush();
        idle();
        ex_drive(5'd0, 32'h1111);
        tick();
        n_tests++; if (o_rd_we !== 1'b0) begin n_fail++; $display("FAIL x0_we: got %0b want 0", o_rd_we); end
        ex_drive(5'd7, 32'h2222);
        i_pip_flush = 1;
        tick();
        n_tests++; if (o_rd_we !== 1'b0 || o_rd_idx !== 5'd5) begin n_fail++; $display("FAIL flush_ex: got we=%0b idx=%0d want 0/5", o_rd_we, o_rd_idx); end
        idle();
        i_pip_flush = 1; i_lsu_issue = 1; i_lsu_issue_idx = 5'd9;
        tick();
        idle();
        n_tests++; if (o_busy_mask !== 32'h0) begin n_fail++; $display("FAIL flush_issue: got %h want 0", o_busy_mask); end
    endtask

    task automatic test_starvation();
        idle();
        ex_drive(5'd6, 32'h1234);
        i_lsu_valid = 1; i_lsu_rd_idx = 5'd3; i_lsu_rd_data = 32'h55;
        for (int i = 0; i < WAIT_MAX; i++) begin
            #1;
            n_tests++; if (o_lsu_ready !== 1'b0 || o_ex_stall !== 1'b0) begin
                n_fail++; $display("FAIL starve_wait%0d: got ready=%0b stall=%0b want 0/0", i, o_lsu_ready, o_ex_stall); end
            tick();
            n_tests++; if (o_rd_we !== 1'b1 || o_rd_idx !== 5'd6) begin
                n_fail++; $display("FAIL starve_ex%0d: got we=%0b idx=%0d want 1/6", i, o_rd_we, o_rd_idx); end
            i_ex_rd_data = 32'h1234;
        end
        #1;
        n_tests++; if (o_lsu_ready !== 1'b1 || o_ex_stall !== 1'b1) begin
            n_fail++; $display("FAIL starve_grant: got ready=%0b stall=%0b want 1/1", o_lsu_ready, o_ex_stall); end
        tick();
        i_lsu_valid = 0;
        n_tests++; if (o_rd_we !== 1'b1 || o_rd_idx !== 5'd3 || o_rd_data !== 32'h55) begin
            n_fail++; $display("FAIL starve_lsu_write: got we=%0b idx=%0d data=%h want 1/3/55", o_rd_we, o_rd_idx, o_rd_data); end
        #1;
        n_tests++; if (o_ex_stall !== 1'b0) begin n_fail++; $display("FAIL starve_held_stall: got %0b want 0", o_ex_stall); end
        tick();
        idle();
        n_tests++; if (o_rd_we !== 1'b1 || o_rd_idx !== 5'd6 || o_rd_data !== 32'h1234) begin
            n_fail++; $display("FAIL starve_held_write: got we=%0b idx=%0d data=%h want 1/6/1234", o_rd_we, o_rd_idx, o_rd_data); end
        tick();
    endtask

    task automatic test_scoreboard();
        idle();
        i_lsu_issue = 1; i_lsu_issue_idx = 5'd12;
        tick();
        idle();
        n_tests++; if (o_busy_mask !== 32'h1000) begin n_fail++; $display("FAIL sb_set: got %h want 1000", o_busy_mask); end
        i_lsu_valid = 1; i_lsu_rd_idx = 5'd12; i_lsu_rd_data = 32'hC0C0;
        #1;
        n_tests++; if (o_lsu_ready !== 1'b1) begin n_fail++; $display("FAIL sb_ready: got %0b want 1", o_lsu_ready); end
        tick();
        idle();
        n_tests++; if (o_busy_mask !== 32'h0 || o_rd_we !== 1'b1 || o_rd_idx !== 5'd12) begin
            n_fail++; $display("FAIL sb_clear: got mask=%h we=%0b idx=%0d want 0/1/12", o_busy_mask, o_rd_we, o_rd_idx); end
        i_lsu_valid = 1; i_lsu_rd_idx = 5'd12; i_lsu_issue = 1; i_lsu_issue_idx = 5'd12;
        tick();
        idle();
        n_tests++; if (o_busy_mask !== 32'h1000) begin n_fail++; $display("FAIL sb_set_wins: got %h want 1000", o_busy_mask); end
        i_lsu_valid = 1; i_lsu_rd_idx = 5'd12; i_lsu_issue = 1; i_lsu_issue_idx = 5'd20;
        tick();
        idle();
        n_tests++; if (o_busy_mask !== 32'h0010_0000) begin n_fail++; $display("FAIL sb_both: got %h want 00100000", o_busy_mask); end
        i_lsu_valid = 1; i_lsu_rd_idx = 5'd4; i_lsu_rd_data = 32'h44;
        tick();
        idle();
        n_tests++; if (o_busy_mask !== 32'h0010_0000 || o_rd_we !== 1'b1 || o_rd_idx !== 5'd4) begin
            n_fail++; $display("FAIL sb_not_busy: got mask=%h we=%0b idx=%0d want 00100000/1/4", o_busy_mask, o_rd_we, o_rd_idx); end
        i_lsu_valid = 1; i_lsu_rd_idx = 5'd0;
        tick();
        i_lsu_rd_idx = 5'd20;
        n_tests++; if (o_rd_we !== 1'b0) begin n_fail++; $display("FAIL sb_lsu_x0: got we=%0b want 0", o_rd_we); end
        tick();
        idle();
        n_tests++; if (o_busy_mask !== 32'h0) begin n_fail++; $display("FAIL sb_clear20: got %h want 0", o_busy_mask); end
    endtask

    task automatic test_idle_lsu();
        idle();
        for (int i = 0; i < 6; i++) begin
            i_lsu_valid = 1; i_lsu_rd_idx = 5'(i + 1); i_lsu_rd_data = 32'(i);
            #1;
            n_tests++; if (o_lsu_ready !== 1'b1 || o_ex_stall !== 1'b0) begin
                n_fail++; $display("FAIL idle_lsu%0d: got ready=%0b stall=%0b want 1/0", i, o_lsu_ready, o_ex_stall); end
            tick();
        end
        ex_drive(5'd8, 32'h88);
        #1;
        n_tests++; if (o_lsu_ready !== 1'b0 || o_ex_stall !== 1'b0) begin
            n_fail++; $display("FAIL idle_lsu_cnt0: got ready=%0b stall=%0b want 0/0", o_lsu_ready, o_ex_stall); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_random();
        bit          hold_ex = 0, hold_lsu = 0, exreq, grant;
        int          m_wait = 0, starve = 0;
        logic [31:0] m_busy = 0, m_data = 0;
        logic        m_we = 0;
        logic [4:0]  m_idx = 0;
        idle();
        rst_sys = 1; tick(); rst_sys = 0; tick();
        for (int c = 0; c < 3000; c++) begin
            if (!hold_ex) begin
                i_ex_valid   = ($urandom_range(0, 3) != 0);
                i_ex_rd_we   = ($urandom_range(0, 5) != 0);
                i_ex_rd_idx  = 5'($urandom_range(0, 31));
                i_ex_rd_data = $urandom;
            end
            if (!hold_lsu) begin
                i_lsu_valid   = ($urandom_range(0, 2) == 0);
                i_lsu_rd_idx  = 5'($urandom_range(0, 7));
                i_lsu_rd_data = $urandom;
            end
            i_pip_flush     = ($urandom_range(0, 9) == 0);
            i_lsu_issue     = ($urandom_range(0, 3) == 0);
            i_lsu_issue_idx = 5'($urandom_range(0, 7));
            #1;
            exreq = i_ex_valid && i_ex_rd_we && i_ex_rd_idx != 0 && !i_pip_flush;
            grant = i_lsu_valid && (!exreq || m_wait >= WAIT_MAX);
            n_tests++; if (o_lsu_ready !== grant || o_ex_stall !== (exreq && grant)) begin
                n_fail++; $display("FAIL rnd_hs c%0d: got ready=%0b stall=%0b want %0b/%0b", c, o_lsu_ready, o_ex_stall, grant, exreq && grant); end
            n_tests++; if (o_busy_mask !== m_busy) begin
                n_fail++; $display("FAIL rnd_busy c%0d: got %h want %h", c, o_busy_mask, m_busy); end
            starve = (i_lsu_valid && !o_lsu_ready) ? starve + 1 : 0;
            n_tests++; if (starve > WAIT_MAX) begin
                n_fail++; $display("FAIL rnd_starve c%0d: got %0d waits want <=%0d", c, starve, WAIT_MAX); end
            if (grant) begin
                m_we = (i_lsu_rd_idx != 0); m_idx = i_lsu_rd_idx; m_data = i_lsu_rd_data;
            end else if (exreq) begin
                m_we = 1; m_idx = i_ex_rd_idx; m_data = i_ex_rd_data;
            end else begin
                m_we = 0;
            end
            m_wait = (!i_lsu_valid || grant) ? 0 : (m_wait < WAIT_MAX ? m_wait + 1 : WAIT_MAX);
            if (grant) m_busy[i_lsu_rd_idx] = 1'b0;
            if (i_lsu_issue && !i_pip_flush && i_lsu_issue_idx != 0) m_busy[i_lsu_issue_idx] = 1'b1;
            m_busy[0] = 1'b0;
            hold_ex  = exreq && grant;
            hold_lsu = i_lsu_valid && !grant;
            tick();
            n_tests++; if (o_rd_we !== m_we || (m_we && (o_rd_idx !== m_idx || o_rd_data !== m_data))) begin
                n_fail++; $display("FAIL rnd_wb c%0d: got we=%0b idx=%0d data=%h want %0b/%0d/%h", c, o_rd_we, o_rd_idx, o_rd_data, m_we, m_idx, m_data); end
        end
        idle();
        tick();
    endtask

    initial begin
        idle();
        rst_sys = 1;
        tick(); tick();
        rst_sys = 0;
        tick();
        test_reset();
        test_ex_only();
        test_x0_flush();
        test_starvation();
        test_scoreboard();
        test_idle_lsu();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
